umi_burst_framer: RTL and testbench
===================================

UMI_BURST_FRAMER -- requirements
Module: umi_burst_framer

Interface
REQ-001 SHALL have parameter NUM_QUEUES, default 1: number of independent framing channels.
REQ-002 SHALL have parameter DW, default 256: UMI packet width in bits.
REQ-003 SHALL have parameter MAX_BURST, default 16: maximum beats per burst; legal range 1..256.
REQ-004 SHALL have parameter TIMEOUT, default 32: idle cycles before a held beat closes its burst; legal range >=1.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port in_packet, input, NUM_QUEUES*DW: channel i occupies bits [i*DW +: DW].
REQ-008 SHALL have port in_valid, input, NUM_QUEUES: per-channel input valid.
REQ-009 SHALL have port in_ready, output, NUM_QUEUES: per-channel input ready.
REQ-010 SHALL have port flush, input, NUM_QUEUES: per-channel request to close the pending burst.
REQ-011 SHALL have port out_data, output, NUM_QUEUES*DW: framed beat payload.
REQ-012 SHALL have port out_dest, output, NUM_QUEUES*32: beat destination.
REQ-013 SHALL have port out_last, output, NUM_QUEUES: asserted on the final beat of a burst.
REQ-014 SHALL have port out_valid, output, NUM_QUEUES; port out_ready, input, NUM_QUEUES.

Function (per channel; channels fully independent)
REQ-015 SHALL compute a beat's dest as {16'h0000, packet[DW-1 -: 16]}.
REQ-016 SHALL keep a one-beat hold register H (valid, data, dest) and an output register O (valid, data, dest, last) driving out_*.
REQ-017 SHALL define can_load = !O.valid || out_ready.
REQ-018 SHALL drive in_ready = !H.valid || can_load, combinationally, with no dependency on in_valid.
REQ-019 SHALL, on accept (in_valid && in_ready) with H empty, load H; O is unchanged.
REQ-020 SHALL, on accept with H valid, move H to O with last = (in dest != H.dest) || (beat_cnt == MAX_BURST-1), and load H with the input in the same cycle.
REQ-021 SHALL, when H valid, no accept, can_load, and (idle_cnt == TIMEOUT-1 || flush), move H to O with last=1 and clear H.valid.
REQ-022 SHALL, when none of REQ-020/021 loads O and out_ready is high, clear O.valid.
REQ-023 SHALL hold out_data, out_dest and out_last stable while out_valid && !out_ready.
REQ-024 SHALL maintain beat_cnt (8 bits): it clears when O loads with last=1 and increments when O loads with last=0.
REQ-025 SHALL maintain idle_cnt: it clears on accept or when H is empty, and otherwise increments, saturating at TIMEOUT-1.
REQ-026 SHALL ignore flush when H is empty.
REQ-027 SHALL treat flush coincident with accept as no flush, because REQ-020 takes priority.
REQ-028 SHALL, for MAX_BURST=1, mark every beat last=1.
REQ-029 SHALL give the first beat a minimum latency of input accept to out_valid of 2 cycles with back-to-back traffic, or TIMEOUT+1 cycles when it is the sole beat.
REQ-030 SHALL sustain throughput of 1 beat/cycle per channel when out_ready is held high.

Reset
REQ-031 SHALL, while reset is high at a clock edge, clear H.valid, O.valid, out_last, out_data, out_dest, beat_cnt and idle_cnt to 0.
REQ-032 SHALL drop held and in-flight beats when reset occurs mid-burst; the next burst starts at beat_cnt=0.
REQ-033 SHALL drive in_ready=1 and out_valid=0 in the first cycle after reset deasserts.

Structure
REQ-034 SHALL place the UMI_DEST_W=16 and UMI_DEST_PAD_W=16 constants and the beat-record typedef (data, dest, last) in shared package umi_fpga_pkg.
REQ-035 SHALL implement one channel in sub-module umi_burst_framer_ch, instantiated NUM_QUEUES times by a generate loop.
REQ-036 SHALL contain no combinational path from out_ready to out_valid/out_data.

Verification
REQ-037 SHALL cover: 4 packets, dest 0x0005, back-to-back, out_ready=1, TIMEOUT=8 -> 4 beats, out_last=0,0,0,1, the last beat 8 cycles after the 4th accept.
REQ-038 SHALL cover: MAX_BURST=4, 10 packets, same dest -> out_last on beats 4, 8 and 10.
REQ-039 SHALL cover: dests 0x0001,0x0001,0x0002 -> out_last=0,1 on the first two beats; the third beat is held until timeout, then last=1.
REQ-040 SHALL cover: 1 packet, flush pulse 2 cycles after accept -> out_valid next cycle with last=1, no timeout wait.
REQ-041 SHALL cover: out_ready low for 5 cycles with 3 packets offered -> the 2 accepted beats are held, in_ready=0, and out_data stays stable; after release, the sequence is intact with no loss or duplication.
REQ-042 SHALL cover: NUM_QUEUES=2, reset asserted mid-burst on channel 0 while channel 1 streams -> all outputs 0; after release, both channels frame new bursts from beat_cnt=0.

Source files
------------

// File: rtl/umi_fpga_pkg.sv
// Shared UMI constants and types used by the burst framer and its channels.
package umi_fpga_pkg;

  localparam int UMI_DEST_W     = 16;
  localparam int UMI_DEST_PAD_W = 16;
  localparam int UMI_DW         = 256;

  // Beat record at the default packet width.
  typedef struct packed {
    logic [UMI_DW-1:0]                    data;
    logic [UMI_DEST_PAD_W+UMI_DEST_W-1:0] dest;
    logic                                 last;
  } umi_beat_t;

  // What, if anything, moves into the output register this cycle.
  typedef enum logic [1:0] {
    LOAD_NONE,
    LOAD_PUSH,
    LOAD_CLOSE
  } load_sel_e;

endpackage

// File: rtl/umi_burst_framer_ch.sv
// One framing channel: a hold register H and an output register O; a beat's
// last flag is decided when it leaves H, by the next beat or by timeout/flush.
module umi_burst_framer_ch
  import umi_fpga_pkg::*;
#(
  parameter int DW        = 256,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_packet,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [DW-1:0] out_data,
  output logic [31:0]   out_dest,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int              IW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0]   IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [7:0]      BEAT_LAST = 8'(MAX_BURST - 1);
  localparam int              DEST_W    = UMI_DEST_PAD_W + UMI_DEST_W;

  logic              h_valid;
  logic [DW-1:0]     h_data;
  logic [DEST_W-1:0] h_dest;
  logic [7:0]        beat_cnt;
  logic [IW-1:0]     idle_cnt;

  logic [DEST_W-1:0] in_dest;
  logic              can_load;
  logic              accept;
  logic              load_last;
  load_sel_e         load_sel;

  assign in_dest = {{UMI_DEST_PAD_W{1'b0}}, in_packet[DW-1 -: UMI_DEST_W]};

  // A new beat pushes H out and outranks any timeout or flush close.
  always_comb begin
    can_load  = !out_valid || out_ready;
    in_ready  = !h_valid || can_load;
    accept    = in_valid && in_ready;
    load_sel  = LOAD_NONE;
    load_last = 1'b1;
    if (accept && h_valid) begin
      load_sel  = LOAD_PUSH;
      load_last = (in_dest != h_dest) || (beat_cnt == BEAT_LAST);
    end else if (h_valid && can_load && ((idle_cnt == IDLE_LAST) || flush)) begin
      load_sel  = LOAD_CLOSE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_valid   <= 1'b0;
      h_data    <= '0;
      h_dest    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dest  <= '0;
      out_last  <= 1'b0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
    end else begin
      if (load_sel != LOAD_NONE) begin
        out_valid <= 1'b1;
        out_data  <= h_data;
        out_dest  <= h_dest;
        out_last  <= load_last;
        beat_cnt  <= load_last ? '0 : beat_cnt + 8'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        h_valid <= 1'b1;
        h_data  <= in_packet;
        h_dest  <= in_dest;
      end else if (load_sel == LOAD_CLOSE) begin
        h_valid <= 1'b0;
      end

      if (accept || !h_valid) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_LAST) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/umi_burst_framer.sv
// Multi-channel UMI burst framer: NUM_QUEUES independent framing channels.
module umi_burst_framer
  import umi_fpga_pkg::*;
#(
  parameter int NUM_QUEUES = 1,
  parameter int DW         = 256,
  parameter int MAX_BURST  = 16,
  parameter int TIMEOUT    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_QUEUES*DW-1:0] in_packet,
  input  logic [NUM_QUEUES-1:0]  in_valid,
  output logic [NUM_QUEUES-1:0]  in_ready,
  input  logic [NUM_QUEUES-1:0]  flush,
  output logic [NUM_QUEUES*DW-1:0] out_data,
  output logic [NUM_QUEUES*(UMI_DEST_PAD_W+UMI_DEST_W)-1:0] out_dest,
  output logic [NUM_QUEUES-1:0]  out_last,
  output logic [NUM_QUEUES-1:0]  out_valid,
  input  logic [NUM_QUEUES-1:0]  out_ready
);

  localparam int DEST_W = UMI_DEST_PAD_W + UMI_DEST_W;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_ch
    umi_burst_framer_ch #(
      .DW        (DW),
      .MAX_BURST (MAX_BURST),
      .TIMEOUT   (TIMEOUT)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .in_packet (in_packet[i*DW +: DW]),
      .in_valid  (in_valid[i]),
      .in_ready  (in_ready[i]),
      .flush     (flush[i]),
      .out_data  (out_data[i*DW +: DW]),
      .out_dest  (out_dest[i*DEST_W +: DEST_W]),
      .out_last  (out_last[i]),
      .out_valid (out_valid[i]),
      .out_ready (out_ready[i])
    );
  end

endmodule

// File: tb/tb_umi_burst_framer.sv
// Self-checking bench for umi_burst_framer: directed table, corner sequences,
// and randomized traffic against a transaction-level scoreboard.
module tb_umi_burst_framer;

  localparam int NQ = 2;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NQ*DW-1:0]  in_packet;
  logic [NQ-1:0]     in_valid, in_ready, flush, out_last, out_valid, out_ready;
  logic [NQ*DW-1:0]  out_data;
  logic [NQ*32-1:0]  out_dest;

  logic [DW-1:0] p1_packet, p1_data;
  logic [31:0]   p1_dest;
  logic          p1_valid, p1_ready, p1_flush, p1_last, p1_ovalid, p1_oready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  umi_burst_framer #(.NUM_QUEUES(NQ), .DW(DW), .MAX_BURST(MB), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset), .in_packet(in_packet), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_dest(out_dest),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready));

  umi_burst_framer #(.NUM_QUEUES(1), .DW(DW), .MAX_BURST(1), .TIMEOUT(4)) u_mb1 (
    .clk(clk), .reset(reset), .in_packet(p1_packet), .in_valid(p1_valid),
    .in_ready(p1_ready), .flush(p1_flush), .out_data(p1_data), .out_dest(p1_dest),
    .out_last(p1_last), .out_valid(p1_ovalid), .out_ready(p1_oready));

  typedef struct packed {
    logic        iv;
    logic [31:0] pk;
    logic        fl;
    logic        ov;
    logic        last;
    logic [31:0] od;
  } vec_t;

  vec_t        tbl[22];
  logic [31:0] rx_d[NQ][$];
  logic        rx_l[NQ][$];
  int          rx_c[NQ][$];
  logic        p1_rxl[$];
  logic [31:0] ex_d[$];
  logic        ex_l[$];

  logic [31:0] acc[NQ][$];
  int          ld_n[NQ], bpos[NQ];
  logic        pv_ov[NQ], pv_or[NQ], pv_l[NQ];
  logic [31:0] pv_d[NQ];

  function automatic vec_t mk(logic iv, logic [31:0] pk, logic fl, logic ov,
                              logic last, logic [31:0] od);
    vec_t v;
    v.iv = iv; v.pk = pk; v.fl = fl; v.ov = ov; v.last = last; v.od = od;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic iv, input logic [31:0] pk);
    in_valid[c] = iv;
    in_packet[c*DW +: DW] = pk;
  endtask

  // Record every handshake that will happen at the coming edge, then advance.
  task automatic step();
    #1;
    for (int c = 0; c < NQ; c++) begin
      if (out_valid[c] && out_ready[c]) begin
        rx_d[c].push_back(out_data[c*DW +: DW]);
        rx_l[c].push_back(out_last[c]);
        rx_c[c].push_back(cyc);
      end
    end
    if (p1_ovalid && p1_oready) p1_rxl.push_back(p1_last);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    for (int c = 0; c < NQ; c++) begin
      rx_d[c].delete(); rx_l[c].delete(); rx_c[c].delete();
    end
    ex_d.delete(); ex_l.delete();
  endtask

  task automatic compare_rx(input string nm, input int c);
    chk({nm, "_count"}, rx_d[c].size(), ex_d.size());
    for (int i = 0; i < ex_d.size() && i < rx_d[c].size(); i++) begin
      chk({nm, "_data"}, rx_d[c][i], ex_d[i]);
      chk({nm, "_last"}, rx_l[c][i], ex_l[i]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = '0; flush = '0; out_ready = '1; in_packet = '0;
    p1_valid = 1'b0; p1_flush = 1'b0; p1_oready = 1'b1; p1_packet = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int acc3;
    logic [31:0] pk;
    logic exp_rdy, exp_last;
    int idx, pv;

    // ---- reset state ----
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_dest", out_dest, 0);
    #1;
    chk("rst_in_ready", in_ready, 2'b11);

    // ---- table: back-to-back burst with timeout close, flush cases ----
    tbl[0]  = mk(1, 32'h0005_0001, 0, 0, 0, 0);
    tbl[1]  = mk(1, 32'h0005_0002, 0, 1, 0, 32'h0005_0001);
    tbl[2]  = mk(1, 32'h0005_0003, 0, 1, 0, 32'h0005_0002);
    tbl[3]  = mk(1, 32'h0005_0004, 0, 1, 0, 32'h0005_0003);
    for (int i = 4; i <= 10; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 1, 32'h0005_0004);
    tbl[12] = mk(0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 32'h0009_0005, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 1, 1, 1, 32'h0009_0005);
    tbl[16] = mk(0, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 1, 0, 0, 0);
    tbl[18] = mk(1, 32'h0009_0006, 1, 0, 0, 0);
    tbl[19] = mk(1, 32'h0009_0007, 1, 1, 0, 32'h0009_0006);
    tbl[20] = mk(0, 0, 1, 1, 1, 32'h0009_0007);
    tbl[21] = mk(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) begin
      drive(0, tbl[i].iv, tbl[i].pk);
      flush[0] = tbl[i].fl;
      #1;
      chk("tbl_in_ready", in_ready[0], 1);
      tick();
      chk("tbl_out_valid", out_valid[0], tbl[i].ov);
      if (tbl[i].ov) begin
        chk("tbl_out_last", out_last[0], tbl[i].last);
        chk("tbl_out_data", out_data[DW-1:0], tbl[i].od);
        chk("tbl_out_dest", out_dest[31:0], {16'h0, tbl[i].od[31:16]});
      end
    end
    flush = '0;
    drive(0, 0, 0);

    // ---- MAX_BURST boundary: 10 beats, last on 4, 8, 10 ----
    clear_rx();
    for (int k = 0; k < 10; k++) begin
      pk = {16'h0003, 16'(16'h0100 + k)};
      drive(0, 1, pk);
      ex_d.push_back(pk);
      ex_l.push_back(k == 3 || k == 7 || k == 9);
      step();
    end
    drive(0, 0, 0);
    for (int k = 0; k < 3*TO; k++) step();
    compare_rx("maxburst", 0);

    // ---- dest change closes a burst; final beat waits for timeout ----
    clear_rx();
    acc3 = 0;
    for (int k = 0; k < 3; k++) begin
      pk = {(k == 2) ? 16'h0002 : 16'h0001, 16'(16'h00A1 + k)};
      drive(0, 1, pk);
      ex_d.push_back(pk);
      ex_l.push_back(k != 0);
      acc3 = cyc;
      step();
    end
    drive(0, 0, 0);
    for (int k = 0; k < 3*TO; k++) step();
    compare_rx("destchg", 0);
    if (rx_c[0].size() == 3) chk("destchg_timeout_lat", rx_c[0][2] - acc3, TO + 1);

    // ---- backpressure: out_ready low for 5 cycles ----
    clear_rx();
    out_ready[0] = 1'b0;
    drive(0, 1, 32'h0007_0A01);
    #1; chk("bp_rdy_a", in_ready[0], 1); step();
    drive(0, 1, 32'h0007_0A02);
    #1; chk("bp_rdy_b", in_ready[0], 1); step();
    drive(0, 1, 32'h0007_0A03);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy_stall", in_ready[0], 0);
      chk("bp_hold_valid", out_valid[0], 1);
      chk("bp_hold_data", out_data[DW-1:0], 32'h0007_0A01);
      chk("bp_hold_last", out_last[0], 0);
      step();
    end
    out_ready[0] = 1'b1;
    #1; chk("bp_rdy_release", in_ready[0], 1); step();
    drive(0, 0, 0);
    for (int k = 0; k < 3*TO; k++) step();
    ex_d = '{32'h0007_0A01, 32'h0007_0A02, 32'h0007_0A03};
    ex_l = '{1'b0, 1'b0, 1'b1};
    compare_rx("bp", 0);

    // ---- MAX_BURST=1: every beat is last ----
    p1_rxl.delete();
    for (int k = 0; k < 3; k++) begin
      p1_valid = 1'b1; p1_packet = {16'h0005, 16'(k)};
      step();
    end
    p1_valid = 1'b0;
    for (int k = 0; k < 16; k++) step();
    chk("mb1_count", p1_rxl.size(), 3);
    foreach (p1_rxl[i]) chk("mb1_last", p1_rxl[i], 1);

    // ---- reset mid-burst on ch0 while ch1 streams ----
    drive(0, 1, 32'h0003_0D01); drive(1, 1, 32'h0004_0E01); step();
    drive(0, 1, 32'h0003_0D02); drive(1, 1, 32'h0004_0E02); step();
    drive(1, 1, 32'h0004_0E03); drive(0, 0, 0);
    reset = 1'b1; step();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_dest", out_dest, 0);
    reset = 1'b0;
    in_valid = '0;
    #1;
    chk("midrst_in_ready", in_ready, 2'b11);
    chk("midrst_valid_after", out_valid, 0);
    clear_rx();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, {16'h0003, 16'(16'h0200 + k)});
      drive(1, 1, {16'h0004, 16'(16'h0300 + k)});
      ex_l.push_back(k >= 3);
      step();
    end
    in_valid = '0;
    for (int k = 0; k < 3*TO; k++) step();
    for (int k = 0; k < 5; k++) ex_d.push_back({16'h0003, 16'(16'h0200 + k)});
    compare_rx("postrst_ch0", 0);
    ex_d.delete();
    for (int k = 0; k < 5; k++) ex_d.push_back({16'h0004, 16'(16'h0300 + k)});
    compare_rx("postrst_ch1", 1);

    // ---- randomized traffic against a transaction scoreboard ----
    do_reset();
    for (int c = 0; c < NQ; c++) begin
      acc[c].delete(); ld_n[c] = 0; bpos[c] = 0;
    end
    for (int i = 0; i < 2000 + 3*TO; i++) begin
      pv = (i >= 2000) ? 0 : (((i / 250) % 2) != 0 ? 85 : 20);
      for (int c = 0; c < NQ; c++) begin
        pk = {16'($urandom_range(1, 2)), 16'($urandom)};
        drive(c, $urandom_range(0, 99) < pv, pk);
        flush[c]     = (i < 2000) && ($urandom_range(0, 9) == 0);
        out_ready[c] = (i >= 2000) || ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int c = 0; c < NQ; c++) begin
        exp_rdy = (acc[c].size() == ld_n[c]) || !out_valid[c] || out_ready[c];
        chk("rnd_in_ready", in_ready[c], exp_rdy);
        if (in_valid[c] && exp_rdy) acc[c].push_back(in_packet[c*DW +: DW]);
        pv_ov[c] = out_valid[c]; pv_or[c] = out_ready[c];
        pv_d[c]  = out_data[c*DW +: DW]; pv_l[c] = out_last[c];
      end
      tick();
      for (int c = 0; c < NQ; c++) begin
        if (pv_ov[c] && !pv_or[c]) begin
          chk("rnd_stall_valid", out_valid[c], 1);
          chk("rnd_stall_data", out_data[c*DW +: DW], pv_d[c]);
          chk("rnd_stall_last", out_last[c], pv_l[c]);
        end else if (out_valid[c]) begin
          idx = ld_n[c];
          if (idx >= acc[c].size()) begin
            chk("rnd_extra_beat", idx, acc[c].size() - 1);
          end else begin
            // A beat closed by its successor is last only on dest change or a full burst.
            if (acc[c].size() > idx + 1)
              exp_last = (acc[c][idx+1][31:16] != acc[c][idx][31:16]) || (bpos[c] == MB - 1);
            else
              exp_last = 1'b1;
            chk("rnd_data", out_data[c*DW +: DW], acc[c][idx]);
            chk("rnd_dest", out_dest[c*32 +: 32], {16'h0, acc[c][idx][31:16]});
            chk("rnd_last", out_last[c], exp_last);
            bpos[c] = exp_last ? 0 : bpos[c] + 1;
            ld_n[c]++;
          end
        end
      end
    end
    for (int c = 0; c < NQ; c++) chk("rnd_drain", ld_n[c], acc[c].size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
